// File: rtl/w_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w_writeback_pkg
// Description : Shared pipeline encodings for the write-back source select
//               (WDSel) and load type (LdType). The decoder uses the same
//               constants. Also defines the W-stage register record.
// Revision    : 1.0 - initial release
// ============================================================================
package w_writeback_pkg;

    // Write-back data source select
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;
    localparam logic [1:0] WD_MD  = 2'd3;

    // Load type; encodings 5..7 behave as LD_W
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // Fields latched from the M stage
    typedef struct packed {
        logic [31:0] pc;
        logic        rfwr;
        logic [4:0]  a3;
        logic [1:0]  wdsel;
        logic [2:0]  ldtype;
        logic [31:0] aluout;
        logic [31:0] dmrd;
        logic [31:0] mdout;
        logic        valid;
    } w_stage_t;

endpackage : w_writeback_pkg
`default_nettype wire

// File: rtl/w_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : w_writeback_if
// Description : M->W pipeline fields and the register-file write port driven
//               by the write-back stage.
//               master : upstream side, drives M_* and observes W_*
//               slave  : write-back stage, consumes M_* and drives W_*
// Revision    : 1.0 - initial release
// ============================================================================
interface w_writeback_if;
    logic [31:0] M_PC;
    logic        M_RFWr;
    logic [4:0]  M_A3;
    logic [1:0]  M_WDSel;
    logic [2:0]  M_LdType;
    logic [31:0] M_ALUOut;
    logic [31:0] M_DMRD;
    logic [31:0] M_MDOut;

    logic [31:0] W_PC;
    logic        W_RFWr;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic        W_Valid;
    logic [31:0] W_Commits;

    modport master (
        output M_PC, M_RFWr, M_A3, M_WDSel, M_LdType, M_ALUOut, M_DMRD, M_MDOut,
        input  W_PC, W_RFWr, W_A3, W_WD, W_Valid, W_Commits
    );

    modport slave (
        input  M_PC, M_RFWr, M_A3, M_WDSel, M_LdType, M_ALUOut, M_DMRD, M_MDOut,
        output W_PC, W_RFWr, W_A3, W_WD, W_Valid, W_Commits
    );
endinterface : w_writeback_if
`default_nettype wire

// File: rtl/w_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : w_load_ext
// Description : Combinational load-data extraction. Picks the byte/halfword
//               addressed by the offset out of the aligned memory word and
//               sign- or zero-extends it.
//   i_raw   [31:0] raw aligned data-memory word
//   i_off   [1:0]  byte offset (ALUOut[1:0])
//   i_type  [2:0]  load type (LD_*)
//   o_data  [31:0] extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module w_load_ext
    import w_writeback_pkg::*;
(
    input  wire logic [31:0] i_raw,
    input  wire logic [1:0]  i_off,
    input  wire logic [2:0]  i_type,
    output logic      [31:0] o_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane selected by shifting the word down by 8*offset
    assign w_shifted = i_raw >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    // Halfword lane ignores off[0]
    assign w_half    = i_off[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_data = i_raw;
        case (i_type)
            LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_data = {24'h000000, w_byte};
            LD_H:    o_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_raw;
        endcase
    end

endmodule : w_load_ext
`default_nettype wire

// File: rtl/w_writeback.sv
`default_nettype none
// ============================================================================
// Module      : w_writeback
// Description : MIPS write-back stage. Latches the M->W fields, extracts load
//               data, selects the write-back value and drives the register
//               file write port (also the W-stage forwarding source). Keeps a
//               count of performed register writes.
//   Clk, Rst      clock, asynchronous active-high reset
//   En            stage enable (0 holds)
//   Clr           synchronous bubble insert, wins over En
//   bus (slave)   M_* inputs, W_* register-file / trace outputs
// Parameters:
//   RESET_PC      PC shown after reset or a bubble
// Revision    : 1.0 - initial release
// ============================================================================
module w_writeback
    import w_writeback_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
)
(
    input  wire logic    Clk,
    input  wire logic    Rst,
    input  wire logic    En,
    input  wire logic    Clr,
    w_writeback_if.slave bus
);

    w_stage_t    r_stage;
    logic [31:0] r_commits;

    logic [31:0] w_ld_data;
    logic [31:0] w_pc8;
    logic [31:0] w_wd;
    logic        w_rfwr;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stage       <= '0;
            r_stage.pc    <= RESET_PC;
        end else if (Clr) begin
            // Bubble: only the fields that make it look like a real
            // instruction are cleared; data fields keep their old values.
            r_stage.pc    <= RESET_PC;
            r_stage.valid <= 1'b0;
            r_stage.rfwr  <= 1'b0;
            r_stage.a3    <= 5'd0;
        end else if (En) begin
            r_stage.pc     <= bus.M_PC;
            r_stage.rfwr   <= bus.M_RFWr;
            r_stage.a3     <= bus.M_A3;
            r_stage.wdsel  <= bus.M_WDSel;
            r_stage.ldtype <= bus.M_LdType;
            r_stage.aluout <= bus.M_ALUOut;
            r_stage.dmrd   <= bus.M_DMRD;
            r_stage.mdout  <= bus.M_MDOut;
            r_stage.valid  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and write-back mux (registered fields only)
    // ------------------------------------------------------------------
    w_load_ext u_load_ext (
        .i_raw  (r_stage.dmrd),
        .i_off  (r_stage.aluout[1:0]),
        .i_type (r_stage.ldtype),
        .o_data (w_ld_data)
    );

    assign w_pc8 = r_stage.pc + 32'd8;

    always_comb begin
        w_wd = r_stage.aluout;
        case (r_stage.wdsel)
            WD_ALU:  w_wd = r_stage.aluout;
            WD_DM:   w_wd = w_ld_data;
            WD_PC8:  w_wd = w_pc8;
            WD_MD:   w_wd = r_stage.mdout;
            default: w_wd = r_stage.aluout;
        endcase
    end

    // $0 is hard-wired zero, so a write to it is never issued
    assign w_rfwr = r_stage.rfwr & r_stage.valid & (r_stage.a3 != 5'd0);

    // ------------------------------------------------------------------
    // Commit counter: one count per cycle the write port is asserted,
    // so a write held by En=0 is counted every cycle it is presented.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_commits <= 32'd0;
        end else if (w_rfwr) begin
            r_commits <= r_commits + 32'd1;
        end
    end

    assign bus.W_PC      = r_stage.pc;
    assign bus.W_RFWr    = w_rfwr;
    assign bus.W_A3      = r_stage.a3;
    assign bus.W_WD      = w_wd;
    assign bus.W_Valid   = r_stage.valid;
    assign bus.W_Commits = r_commits;

endmodule : w_writeback
`default_nettype wire

// File: tb/tb_w_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_writeback
// Description : Self-checking bench for w_writeback. Expected stage contents
//               are pushed to a scoreboard queue when driven and popped when
//               the stage captures them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_writeback;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic En  = 1'b0;
    logic Clr = 1'b0;

    w_writeback_if bus ();

    w_writeback #(.RESET_PC(C_RESET_PC)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .En  (En),
        .Clr (Clr),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic        rfwr;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_commits = 32'd0;

    // Independent reference for the write-back value
    function automatic logic [31:0] model_wd(input logic [31:0] pc, input logic [1:0] wdsel,
                                             input logic [2:0] ld, input logic [31:0] alu,
                                             input logic [31:0] dmrd, input logic [31:0] md);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (alu[1:0])
            2'd0: b = dmrd[7:0];
            2'd1: b = dmrd[15:8];
            2'd2: b = dmrd[23:16];
            default: b = dmrd[31:24];
        endcase
        h = alu[1] ? dmrd[31:16] : dmrd[15:0];
        case (wdsel)
            2'd0: r = alu;
            2'd2: r = pc + 32'd8;
            2'd3: r = md;
            default: begin
                case (ld)
                    3'd1: r = {{24{b[7]}}, b};
                    3'd2: r = {24'd0, b};
                    3'd3: r = {{16{h[15]}}, h};
                    3'd4: r = {16'd0, h};
                    default: r = dmrd;
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic drive(input logic en, input logic clr, input logic [31:0] pc,
                         input logic rfwr, input logic [4:0] a3, input logic [1:0] wdsel,
                         input logic [2:0] ld, input logic [31:0] alu,
                         input logic [31:0] dmrd, input logic [31:0] md);
        exp_t e;
        En           = en;
        Clr          = clr;
        bus.M_PC     = pc;
        bus.M_RFWr   = rfwr;
        bus.M_A3     = a3;
        bus.M_WDSel  = wdsel;
        bus.M_LdType = ld;
        bus.M_ALUOut = alu;
        bus.M_DMRD   = dmrd;
        bus.M_MDOut  = md;
        if (en && !clr) begin
            e.pc    = pc;
            e.rfwr  = rfwr && (a3 != 5'd0);
            e.a3    = a3;
            e.wd    = model_wd(pc, wdsel, ld, alu, dmrd, md);
            e.valid = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic hold();
        En  = 1'b0;
        Clr = 1'b0;
    endtask

    // One clock: account the commit of what is in the stage, then advance
    // the expected stage contents.
    task automatic step();
        if (cur.valid && cur.rfwr) exp_commits = exp_commits + 32'd1;
        @(posedge Clk);
        #1;
        if (Clr) begin
            cur.pc = C_RESET_PC; cur.valid = 1'b0; cur.rfwr = 1'b0; cur.a3 = 5'd0;
        end else if (En && sb.size() > 0) begin
            cur = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        bus.M_PC = '0; bus.M_RFWr = 0; bus.M_A3 = '0; bus.M_WDSel = '0;
        bus.M_LdType = '0; bus.M_ALUOut = '0; bus.M_DMRD = '0; bus.M_MDOut = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        cur.pc = C_RESET_PC; cur.rfwr = 0; cur.a3 = '0; cur.wd = '0; cur.valid = 0;
        checks++; if (bus.W_PC !== C_RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", bus.W_PC, C_RESET_PC); end
        checks++; if (bus.W_RFWr !== 1'b0) begin errors++; $display("FAIL reset_rfwr got %b want 0", bus.W_RFWr); end
        checks++; if (bus.W_A3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got %0d want 0", bus.W_A3); end
        checks++; if (bus.W_WD !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", bus.W_WD); end
        checks++; if (bus.W_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.W_Valid); end
        checks++; if (bus.W_Commits !== 32'd0) begin errors++; $display("FAIL reset_commits got %0d want 0", bus.W_Commits); end
        // A valid write in the stage, then asynchronous reset mid-cycle
        drive(1, 0, 32'h0000_3100, 1, 5'd7, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0);
        step();
        hold();
        checks++; if (bus.W_RFWr !== 1'b1) begin errors++; $display("FAIL pre_rst_rfwr got %b want 1", bus.W_RFWr); end
        #2 Rst = 1'b1;
        #1;
        checks++; if (bus.W_RFWr !== 1'b0 || bus.W_Valid !== 1'b0) begin errors++; $display("FAIL async_rst_rfwr_valid got %b%b want 00", bus.W_RFWr, bus.W_Valid); end
        checks++; if (bus.W_PC !== C_RESET_PC || bus.W_A3 !== 5'd0 || bus.W_WD !== 32'd0) begin errors++; $display("FAIL async_rst_fields got pc=%h a3=%0d wd=%h", bus.W_PC, bus.W_A3, bus.W_WD); end
        @(negedge Clk);
        Rst = 1'b0;
        cur.pc = C_RESET_PC; cur.rfwr = 0; cur.a3 = '0; cur.wd = '0; cur.valid = 0;
        exp_commits = 32'd0;
        step();
        checks++; if (bus.W_Commits !== 32'd0) begin errors++; $display("FAIL async_rst_commits got %0d want 0", bus.W_Commits); end
    endtask

    task automatic test_lb();
        drive(1, 0, 32'h0000_3004, 1, 5'd8, 2'd1, 3'd1, 32'h0000_0003, 32'h80FF_1234, 32'd0);
        step();
        checks++; if (bus.W_WD !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_off3_wd got %h want FFFFFF80", bus.W_WD); end
        checks++; if (bus.W_RFWr !== 1'b1 || bus.W_A3 !== 5'd8) begin errors++; $display("FAIL lb_off3_port got rfwr=%b a3=%0d want 1/8", bus.W_RFWr, bus.W_A3); end
        checks++; if (bus.W_Valid !== 1'b1 || bus.W_PC !== 32'h0000_3004) begin errors++; $display("FAIL lb_off3_pc got valid=%b pc=%h", bus.W_Valid, bus.W_PC); end
    endtask

    task automatic test_loads();
        logic [2:0]  ld[8]   = '{3'd4, 3'd3, 3'd3, 3'd1, 3'd2, 3'd2, 3'd0, 3'd6};
        logic [31:0] off[8]  = '{32'd2, 32'd0, 32'd3, 32'd1, 32'd3, 32'd0, 32'd1, 32'd2};
        logic [31:0] dm[8]   = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h80FF_1234,
                                 32'h80FF_1234, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1357_9BDF};
        drive(1, 0, 32'h0000_3008, 1, 5'd9, 2'd1, 3'd4, 32'd2, 32'h8001_7FFF, 32'd0);
        step();
        checks++; if (bus.W_WD !== 32'h0000_8001) begin errors++; $display("FAIL lhu_off2 got %h want 00008001", bus.W_WD); end
        drive(1, 0, 32'h0000_300C, 1, 5'd9, 2'd1, 3'd3, 32'd0, 32'h8001_7FFF, 32'd0);
        step();
        checks++; if (bus.W_WD !== 32'h0000_7FFF) begin errors++; $display("FAIL lh_off0 got %h want 00007FFF", bus.W_WD); end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'h0000_3200 + 32'(4 * i), 1, 5'(10 + i), 2'd1, ld[i],
                  32'h0000_1000 | off[i], dm[i], 32'd0);
            step();
            checks++;
            if (bus.W_WD !== cur.wd || bus.W_A3 !== cur.a3) begin
                errors++;
                $display("FAIL load_tbl[%0d] got wd=%h a3=%0d want wd=%h a3=%0d", i, bus.W_WD, bus.W_A3, cur.wd, cur.a3);
            end
        end
        checks++; if (bus.W_Commits !== exp_commits) begin errors++; $display("FAIL load_commits got %0d want %0d", bus.W_Commits, exp_commits); end
    endtask

    task automatic test_link_alu_md();
        drive(1, 0, 32'h0000_3010, 1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (bus.W_WD !== 32'h0000_3018 || bus.W_PC !== 32'h0000_3010) begin errors++; $display("FAIL link_taken got wd=%h pc=%h want 00003018/00003010", bus.W_WD, bus.W_PC); end
        checks++; if (bus.W_RFWr !== 1'b1 || bus.W_A3 !== 5'd31) begin errors++; $display("FAIL link_taken_port got rfwr=%b a3=%0d", bus.W_RFWr, bus.W_A3); end
        drive(1, 0, 32'h0000_3014, 0, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (bus.W_RFWr !== 1'b0) begin errors++; $display("FAIL link_untaken_rfwr got %b want 0", bus.W_RFWr); end
        drive(1, 0, 32'hFFFF_FFFC, 1, 5'd3, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (bus.W_Commits !== exp_commits) begin errors++; $display("FAIL link_untaken_commits got %0d want %0d", bus.W_Commits, exp_commits); end
        checks++; if (bus.W_WD !== 32'h0000_0004) begin errors++; $display("FAIL pc8_wrap got %h want 00000004", bus.W_WD); end
        drive(1, 0, 32'h0000_3020, 1, 5'd4, 2'd0, 3'd1, 32'hA5A5_0003, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
        step();
        checks++; if (bus.W_WD !== 32'hA5A5_0003) begin errors++; $display("FAIL alu_sel got %h want A5A50003", bus.W_WD); end
        drive(1, 0, 32'h0000_3024, 1, 5'd5, 2'd3, 3'd1, 32'hA5A5_0003, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
        step();
        checks++; if (bus.W_WD !== 32'h5A5A_5A5A) begin errors++; $display("FAIL md_sel got %h want 5A5A5A5A", bus.W_WD); end
    endtask

    task automatic test_zero_and_bubble();
        drive(1, 0, 32'h0000_3030, 1, 5'd0, 2'd0, 3'd0, 32'h1111_1111, 32'h0, 32'h0);
        step();
        checks++; if (bus.W_RFWr !== 1'b0 || bus.W_Valid !== 1'b1) begin errors++; $display("FAIL zero_dest got rfwr=%b valid=%b want 0/1", bus.W_RFWr, bus.W_Valid); end
        drive(1, 1, 32'h0000_3034, 1, 5'd6, 2'd0, 3'd0, 32'h2222_2222, 32'h0, 32'h0);
        step();
        checks++; if (bus.W_Commits !== exp_commits) begin errors++; $display("FAIL zero_dest_commits got %0d want %0d", bus.W_Commits, exp_commits); end
        checks++; if (bus.W_Valid !== 1'b0 || bus.W_PC !== C_RESET_PC) begin errors++; $display("FAIL bubble got valid=%b pc=%h want 0/%h", bus.W_Valid, bus.W_PC, C_RESET_PC); end
        checks++; if (bus.W_RFWr !== 1'b0 || bus.W_A3 !== 5'd0) begin errors++; $display("FAIL bubble_port got rfwr=%b a3=%0d want 0/0", bus.W_RFWr, bus.W_A3); end
    endtask

    task automatic test_hold();
        logic [31:0] base;
        drive(1, 0, 32'h0000_3040, 1, 5'd12, 2'd0, 3'd0, 32'hBEEF_0001, 32'h0, 32'h0);
        step();
        base = exp_commits;
        drive(0, 0, 32'h0000_9999, 1, 5'd20, 2'd3, 3'd0, 32'h0, 32'h0, 32'h7777_7777);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.W_WD !== 32'hBEEF_0001 || bus.W_A3 !== 5'd12 || bus.W_RFWr !== 1'b1 || bus.W_PC !== 32'h0000_3040) begin
                errors++;
                $display("FAIL hold[%0d] got wd=%h a3=%0d rfwr=%b pc=%h", i, bus.W_WD, bus.W_A3, bus.W_RFWr, bus.W_PC);
            end
        end
        checks++; if (bus.W_Commits !== base + 32'd3) begin errors++; $display("FAIL hold_commits got %0d want %0d", bus.W_Commits, base + 32'd3); end
    endtask

    task automatic test_counter_wrap();
        drive(1, 0, 32'h0000_3050, 1, 5'd9, 2'd0, 3'd0, 32'h0000_0042, 32'h0, 32'h0);
        step();
        hold();
        force dut.r_commits = 32'hFFFF_FFFF;
        #1;
        release dut.r_commits;
        exp_commits = 32'hFFFF_FFFF;
        step();
        checks++; if (bus.W_Commits !== 32'd0) begin errors++; $display("FAIL commit_wrap got %h want 00000000", bus.W_Commits); end
        step();
        checks++; if (bus.W_Commits !== 32'd1) begin errors++; $display("FAIL commit_after_wrap got %h want 00000001", bus.W_Commits); end
        drive(1, 1, 32'h0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        base = exp_commits;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h0000_3060 + 32'(4 * i), 1, 5'(1 + i), 2'd0, 3'd0, 32'h100 + 32'(i), 32'h0, 32'h0);
            step();
            checks++;
            if (bus.W_A3 !== cur.a3 || bus.W_WD !== cur.wd || bus.W_RFWr !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] got a3=%0d wd=%h rfwr=%b want %0d/%h/1", i, bus.W_A3, bus.W_WD, bus.W_RFWr, cur.a3, cur.wd);
            end
        end
        drive(1, 1, 32'h0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        step();
        hold();
        checks++; if (bus.W_Commits !== base + 32'd3) begin errors++; $display("FAIL b2b_commits got %0d want %0d", bus.W_Commits, base + 32'd3); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_loads();
        test_link_alu_md();
        test_zero_and_bubble();
        test_hold();
        test_counter_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_w_writeback
`default_nettype wire

// File: doc/w_writeback.md
# w_writeback

Write-back stage of the five-stage MIPS pipeline: the producer side of the register-file write port. It latches the M→W pipeline fields and applies load-data extraction and sign/zero extension. It selects the write-back value and drives the register file's write interface (PC for trace, write enable, destination, data). The same outputs serve as the W-stage forwarding source for the hazard unit. It also keeps a commit counter for trace and debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value held in W_PC after reset or a bubble.

Ports:
- Clk  in  1  pipeline clock, rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- En  in  1  stage enable; 0 holds all stage registers.
- Clr  in  1  synchronous bubble insert; priority over En.
- M_PC  in  32  PC of the instruction in M.
- M_RFWr  in  1  instruction writes a GPR; already resolved for conditional links such as bgezal.
- M_A3  in  5  destination register.
- M_WDSel  in  2  write-back source: 0 ALU, 1 load, 2 link (PC+8), 3 MD unit.
- M_LdType  in  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5–7 are treated as lw.
- M_ALUOut  in  32  ALU result; bits [1:0] give the load byte offset.
- M_DMRD  in  32  raw aligned data-memory word.
- M_MDOut  in  32  HI/LO or MD result.
- W_PC  out  32  PC of the committing instruction; this is the register file's WPC.
- W_RFWr  out  1  register-file write enable.
- W_A3  out  5  register-file write address.
- W_WD  out  32  register-file write data.
- W_Valid  out  1  stage holds a real instruction, not a bubble.
- W_Commits  out  32  count of performed register writes.

## Operation
- Stage registers hold PC, RFWr, A3, WDSel, LdType, ALUOut, DMRD, MDOut and Valid.
- Register update priority:
  - Rst: asynchronous clear. PC becomes RESET_PC, Valid 0, all other fields 0.
  - Clr: load a bubble. PC becomes RESET_PC, Valid 0, RFWr 0, A3 0.
  - En: capture all M_ fields and set Valid to 1.
  - Otherwise: hold.
- Load extraction is combinational from the registered fields, with off = ALUOut[1:0]:
  - lw: the whole word.
  - lb / lbu: byte DMRD[8·off+7 : 8·off], sign- or zero-extended.
  - lh / lhu: halfword selected by off[1] (off[1]=0 → [15:0], 1 → [31:16]); off[0] is ignored. Sign- or zero-extended.
- W_WD by WDSel:
  - 0: ALUOut.
  - 1: extended load data.
  - 2: PC+8, modulo 2^32.
  - 3: MDOut.
- W_RFWr = RFWr & Valid & (A3 ≠ 0). A write to $0 is never issued.
- W_A3 and W_PC are the registered values. W_WD is driven even when W_RFWr is 0.
- W_Commits increments by 1 on every rising edge where W_RFWr is 1. It wraps from 32'hFFFF_FFFF to 0.

## Timing
- One-cycle latency. M_ fields present at edge n appear on W_ outputs after edge n and are consumed by the register file at edge n+1.
- All W_ outputs are combinational from registers only; there is no M_→W_ combinational path.
- Reset values: W_PC = RESET_PC; W_RFWr 0, W_A3 0, W_WD 0, W_Valid 0, W_Commits 0.
- Rst asserted mid-operation clears the stage immediately and asynchronously. The commit counter does not count the cancelled write.
- Clr and En asserted together: a bubble is inserted and the M_ data is dropped.
- En=0: outputs stay stable, and a held write asserts W_RFWr again each cycle. The commit counter counts each asserted cycle; a held write is not deduplicated.

## Structure
- Shared pipeline package: the WDSel encodings (WD_ALU, WD_DM, WD_PC8, WD_MD) and the LdType encodings (LD_W, LD_B, LD_BU, LD_H, LD_HU). The decoder uses the same constants.
- One sub-module, w_load_ext: purely combinational, with inputs raw word, offset and type, and output the extended word.
- Stage registers and the counter live in w_writeback.

## Test plan
- **Reset:** assert Rst asynchronously mid-cycle with a valid write in the stage. Outputs go to the reset values at once, and W_Commits is 0.
- **lb at offset 3:** M_DMRD=32'h80FF_1234, M_ALUOut=32'h0000_0003, WDSel=1, LdType=lb, A3=8. After one edge: W_WD=32'hFFFF_FF80, W_RFWr=1, W_A3=8.
- **Halfword loads:** lhu at offset 2 of 32'h8001_7FFF gives 32'h0000_8001. lh at offset 0 of the same word gives 32'h0000_7FFF.
- **Link write (bgezal taken):** M_PC=32'h0000_3010, WDSel=2, A3=31, RFWr=1. Result: W_WD=32'h0000_3018 and W_PC=32'h0000_3010. The untaken case (RFWr=0) gives W_RFWr=0 and the counter is unchanged.
- **$0 suppression and bubble:** A3=0 with RFWr=1 gives W_RFWr=0 and no count. Clr=1 together with En=1 gives W_Valid=0 and W_PC=RESET_PC.
- **Counter:** preload via 2^32−1 commits, or force the counter value in simulation. The next commit gives W_Commits=0. Three back-to-back valid writes give +3.
